coincident_edge_recorder: RTL and testbench
===========================================

Name: coincident_edge_recorder

Overview:
- Consumes two single-bit event lines, `a` and `b`, which may toggle in the same clock cycle.
- Detects rising edges on each line and classifies each sampled edge cycle as A-only, B-only or coincident.
- Timestamps each record with a free-running cycle counter and queues it in a small FIFO, read out over a valid/ready interface.
- Sits downstream of the stimulus/driver stage and feeds the checker/monitor, so coincident events are never merged or reordered.

Parameters:
- TS_WIDTH, 16: width of the timestamp counter and of `out_ts`.
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- CNT_WIDTH, 16: width of the saturating statistics counters.

Ports:
- clk  in  1  single clock; everything samples on its rising edge.
- rst  in  1  synchronous, active-high reset.
- a  in  1  event line A; synchronous to clk.
- b  in  1  event line B; synchronous to clk.
- out_valid  out  1  record available at FIFO head.
- out_ready  in  1  consumer accepts the head record when high together with out_valid.
- out_kind  out  2  head record kind: 01 = A only, 10 = B only, 11 = both.
- out_ts  out  TS_WIDTH  head record timestamp.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; set when any record is dropped.
- drop_count  out  CNT_WIDTH  saturating count of dropped records.
- count_both  out  CNT_WIDTH  saturating count of coincident (11) events.

Behaviour:
- Clocking and reset:
  - One clock (`clk`); reset is synchronous and active-high (`rst`).
  - On rst: ts_cnt=0, FIFO empty, out_valid=0, level=0, overflow=0, drop_count=0, count_both=0.
  - out_kind/out_ts are don't-care while out_valid=0; they are driven 0 out of reset.
  - During rst, the previous-value registers a_q/b_q load the current a/b. A level held high through reset therefore never produces an edge.
  - Reset mid-operation discards all queued records and clears all counters in the same edge.
- Timestamp:
  - ts_cnt increments by 1 every non-reset cycle.
  - Wraps modulo 2^TS_WIDTH with no flag.
- Edge detection at clock edge k:
  - ea = a & ~a_q; eb = b & ~b_q.
  - Then a_q<=a, b_q<=b.
  - Falling edges are ignored.
- Record formation:
  - If ea|eb, a record is formed with kind={eb,ea} and ts = ts_cnt value before edge k.
  - A and B rising in the same sampled cycle yield exactly one record of kind 11, never two records.
- Push:
  - The record is written at edge k.
  - out_valid is high from edge k onward if the FIFO was empty (latency: 1 cycle from input change to out_valid).
  - No combinational input-to-output path.
- Pop:
  - Occurs at an edge where out_valid & out_ready.
  - The next record appears at the head after that edge.
  - Records leave in arrival order.
- Simultaneous push and pop:
  - Both take effect; level is unchanged.
  - This is valid when full: the pop frees the slot and the push is accepted (no drop).
  - When empty, a push and a pop cannot coincide because out_valid=0.
- Full without pop:
  - The new record is dropped.
  - overflow<=1 (sticky until rst).
  - drop_count increments, saturating at all-ones.
  - FIFO contents are untouched.
- count_both:
  - Increments on every kind-11 event, including dropped ones.
  - Saturates at all-ones.
- level equals pushes minus pops since reset; range 0..DEPTH.
- out_ready while out_valid=0 has no effect.
- Internal pointers are $clog2(DEPTH) bits and wrap naturally; full and empty are distinguished by the level counter.

Test Plan:
- Coincident edges with out_ready=1:
  - Stimulus: after reset, a and b both rise at cycles 5, 25, 45 (high 10 cycles, low 10 cycles).
  - Required: 3 records, kind=11, ts=5/25/45; count_both=3; no kind 01/10 records.
- Staggered edges:
  - Stimulus: a rises at cycle 10, b rises at cycle 11.
  - Required: records (01,10) then (10,11) in order; count_both=0.
- Overflow (DEPTH=8):
  - Stimulus: out_ready=0, 10 coincident edges.
  - Required: level=8, overflow=1, drop_count=2, count_both=10.
  - Then raising out_ready drains the 8 oldest records in order.
- Full with simultaneous pop and push:
  - Stimulus: FIFO at level 8, out_ready=1 in the same cycle an edge on a arrives.
  - Required: level stays 8, overflow stays 0, and the new record (01) is last out.
- Reset behaviour:
  - Stimulus: hold a=b=1 through rst, release rst.
  - Required: no record is produced.
  - Stimulus: assert rst with level=5.
  - Required: next cycle level=0, out_valid=0, counters=0, ts restarts at 0.
- Timestamp wrap (TS_WIDTH=4):
  - Stimulus: edges at cycles 14 and 18.
  - Required: ts=14 and ts=2.

Source files
------------

// File: rtl/coincident_edge_recorder_if.sv
// Record read-out channel: valid/ready handshake carrying event kind and timestamp.
interface coincident_edge_recorder_if #(
    parameter int TS_WIDTH = 16
);
    logic                out_valid;
    logic                out_ready;
    logic [1:0]          out_kind;
    logic [TS_WIDTH-1:0] out_ts;

    modport master (output out_valid, output out_kind, output out_ts, input out_ready);
    modport slave  (input out_valid, input out_kind, input out_ts, output out_ready);
endinterface

// File: rtl/coincident_edge_recorder.sv
// Rising-edge recorder for two event lines: classifies A/B/coincident edges,
// timestamps them and queues them in a FIFO with drop/coincidence statistics.
module coincident_edge_recorder #(
    parameter int TS_WIDTH  = 16,
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a_i,
    input  logic                       b_i,
    coincident_edge_recorder_if.master out_if,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o,
    output logic [CNT_WIDTH-1:0]       drop_count_o,
    output logic [CNT_WIDTH-1:0]       count_both_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic                 a_q, b_q;
    logic [TS_WIDTH-1:0]  ts_q, ts_d;
    logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;
    logic [CNT_WIDTH-1:0] both_q, both_d;

    logic [1:0]           kind_mem [DEPTH];
    logic [TS_WIDTH-1:0]  ts_mem   [DEPTH];

    logic ea, eb, rec, empty, full, pop, push, drop;

    always_comb begin
        ea    = a_i & ~a_q;
        eb    = b_i & ~b_q;
        rec   = ea | eb;
        empty = (level_q == '0);
        full  = (level_q == LW'(DEPTH));
        pop   = ~empty & out_if.out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push  = rec & (~full | pop);
        drop  = rec & full & ~pop;

        ts_d    = ts_q + TS_WIDTH'(1);
        wr_d    = push ? wr_q + PW'(1) : wr_q;
        rd_d    = pop  ? rd_q + PW'(1) : rd_q;
        level_d = level_q + LW'(push) - LW'(pop);
        ovf_d   = ovf_q | drop;
        drop_d  = (drop && (drop_q != '1)) ? drop_q + CNT_WIDTH'(1) : drop_q;
        both_d  = (ea && eb && (both_q != '1)) ? both_q + CNT_WIDTH'(1) : both_q;
    end

    always_ff @(posedge clk) begin
        // Edge history follows the inputs even in reset, so levels held high
        // through reset do not look like edges afterwards.
        a_q <= a_i;
        b_q <= b_i;
        if (rst) begin
            ts_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
            both_q  <= '0;
        end else begin
            ts_q    <= ts_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            both_q  <= both_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            kind_mem[wr_q] <= {eb, ea};
            ts_mem[wr_q]   <= ts_q;
        end
    end

    assign out_if.out_valid = ~empty;
    assign out_if.out_kind  = empty ? 2'b00 : kind_mem[rd_q];
    assign out_if.out_ts    = empty ? '0 : ts_mem[rd_q];
    assign level_o          = level_q;
    assign overflow_o       = ovf_q;
    assign drop_count_o     = drop_q;
    assign count_both_o     = both_q;
endmodule

// File: tb/tb_coincident_edge_recorder.sv
// Directed bench for coincident_edge_recorder: vector table plus hand-written
// overflow, full-pop-push, reset and timestamp-wrap sequences.
module tb_coincident_edge_recorder;
    logic clk = 1'b0;
    logic rst;
    logic a, b, a_w;
    logic [3:0]  level, level_w;
    logic        ovf, ovf_w;
    logic [15:0] drop, drop_w, both, both_w;

    coincident_edge_recorder_if #(.TS_WIDTH(16)) bus ();
    coincident_edge_recorder_if #(.TS_WIDTH(4))  bus_w ();

    coincident_edge_recorder #(.TS_WIDTH(16), .DEPTH(8), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .a_i(a), .b_i(b), .out_if(bus),
        .level_o(level), .overflow_o(ovf), .drop_count_o(drop), .count_both_o(both)
    );

    coincident_edge_recorder #(.TS_WIDTH(4), .DEPTH(8), .CNT_WIDTH(16)) u_wrap (
        .clk(clk), .rst(rst), .a_i(a_w), .b_i(1'b0), .out_if(bus_w),
        .level_o(level_w), .overflow_o(ovf_w), .drop_count_o(drop_w), .count_both_o(both_w)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [17:0] got_q [$];
    logic [5:0]  got_w [$];

    // Capture every accepted record just before the edge that accepts it.
    always begin
        @(negedge clk);
        #4;
        if (!rst && bus.out_valid && bus.out_ready)
            got_q.push_back({bus.out_kind, bus.out_ts});
        if (!rst && bus_w.out_valid && bus_w.out_ready)
            got_w.push_back({bus_w.out_kind, bus_w.out_ts});
    end

    typedef struct {
        logic        a, b, rdy;
        logic        valid;
        logic [1:0]  kind;
        logic [15:0] ts;
        logic [3:0]  level;
        logic [15:0] both;
    } vec_t;
    vec_t vt [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) cyc++;
        @(negedge clk);
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset(input logic ha, input logic hb);
        a = ha; b = hb; a_w = 1'b0;
        bus.out_ready = 1'b0; bus_w.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        got_q.delete();
        got_w.delete();
    endtask

    initial begin
        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 16'd10, 4'd1, 16'd0};
        vt[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 16'd10, 4'd2, 16'd0};
        vt[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 16'd11, 4'd1, 16'd0};
        vt[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 16'd11, 4'd1, 16'd0};
        vt[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 16'd11, 4'd2, 16'd1};
        vt[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 16'd14, 4'd1, 16'd1};
        vt[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 16'd0,  4'd0, 16'd1};
        vt[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 16'd17, 4'd1, 16'd1};
        vt[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 16'd18, 4'd1, 16'd1};
        vt[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 16'd0,  4'd0, 16'd1};

        // Reset state, observed while rst is still asserted.
        a = 1'b0; b = 1'b0; a_w = 1'b0; rst = 1'b1;
        bus.out_ready = 1'b0; bus_w.out_ready = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ovf",   32'(ovf), 32'd0);
        check("rst_drop",  32'(drop), 32'd0);
        check("rst_both",  32'(both), 32'd0);
        check("rst_kind",  32'(bus.out_kind), 32'd0);
        check("rst_ts",    32'(bus.out_ts), 32'd0);

        // Coincident edges at 5, 25, 45 with the consumer always ready.
        do_reset(1'b0, 1'b0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            goto(5 + 20 * k);  a = 1'b1; b = 1'b1;
            goto(15 + 20 * k); a = 1'b0; b = 1'b0;
        end
        goto(65);
        check("coin_count", 32'(got_q.size()), 32'd3);
        for (int k = 0; k < 3 && k < got_q.size(); k++)
            check($sformatf("coin_rec%0d", k), 32'(got_q[k]), 32'({2'b11, 16'(5 + 20 * k)}));
        check("coin_both",  32'(both), 32'd3);
        check("coin_level", 32'(level), 32'd0);

        // Staggered and mixed edges from the vector table.
        do_reset(1'b0, 1'b0);
        goto(10);
        for (int i = 0; i < 10; i++) begin
            a = vt[i].a; b = vt[i].b; bus.out_ready = vt[i].rdy;
            step();
            check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vt[i].valid));
            check($sformatf("vec%0d_kind", i),  32'(bus.out_kind),  32'(vt[i].kind));
            check($sformatf("vec%0d_ts", i),    32'(bus.out_ts),    32'(vt[i].ts));
            check($sformatf("vec%0d_level", i), 32'(level),         32'(vt[i].level));
            check($sformatf("vec%0d_both", i),  32'(both),          32'(vt[i].both));
        end

        // Overflow: ten coincident edges at even cycles 2..20 with no consumer.
        do_reset(1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            goto(2 + 2 * k); a = 1'b1; b = 1'b1;
            goto(3 + 2 * k); a = 1'b0; b = 1'b0;
            if (k == 7) check("ovf_at_full", 32'(ovf), 32'd0);
        end
        goto(22);
        check("ovf_level", 32'(level), 32'd8);
        check("ovf_flag",  32'(ovf), 32'd1);
        check("ovf_drop",  32'(drop), 32'd2);
        check("ovf_both",  32'(both), 32'd10);
        bus.out_ready = 1'b1;
        goto(34);
        check("drain_count", 32'(got_q.size()), 32'd8);
        for (int k = 0; k < 8 && k < got_q.size(); k++)
            check($sformatf("drain_rec%0d", k), 32'(got_q[k]), 32'({2'b11, 16'(2 + 2 * k)}));
        check("drain_level", 32'(level), 32'd0);
        check("drain_ovf",   32'(ovf), 32'd1);

        // Full FIFO with a pop and an A edge in the same cycle.
        do_reset(1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            goto(2 + 2 * k); a = 1'b1; b = 1'b1;
            goto(3 + 2 * k); a = 1'b0; b = 1'b0;
        end
        goto(18);
        check("full_level_pre", 32'(level), 32'd8);
        a = 1'b1; bus.out_ready = 1'b1;
        step();
        check("full_pp_level", 32'(level), 32'd8);
        check("full_pp_ovf",   32'(ovf), 32'd0);
        check("full_pp_drop",  32'(drop), 32'd0);
        goto(32);
        check("full_pp_count", 32'(got_q.size()), 32'd9);
        if (got_q.size() == 9) begin
            check("full_pp_first", 32'(got_q[0]), 32'({2'b11, 16'd2}));
            check("full_pp_last",  32'(got_q[8]), 32'({2'b01, 16'd18}));
        end

        // Levels held high through reset must not produce records.
        do_reset(1'b1, 1'b1);
        bus.out_ready = 1'b0;
        goto(5);
        check("hold_level", 32'(level), 32'd0);
        check("hold_valid", 32'(bus.out_valid), 32'd0);
        a = 1'b0; b = 1'b0;
        for (int k = 0; k < 5; k++) begin
            goto(6 + 2 * k); a = 1'b1; b = 1'b1;
            goto(7 + 2 * k); a = 1'b0; b = 1'b0;
        end
        goto(17);
        check("mid_level5", 32'(level), 32'd5);
        check("mid_both5",  32'(both), 32'd5);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_both",  32'(both), 32'd0);
        check("mid_rst_drop",  32'(drop), 32'd0);
        rst = 1'b0; cyc = 0;
        goto(3); a = 1'b1;
        step();
        check("restart_kind", 32'(bus.out_kind), 32'd1);
        check("restart_ts",   32'(bus.out_ts), 32'd3);

        // Timestamp wrap on the 4-bit instance.
        do_reset(1'b0, 1'b0);
        bus_w.out_ready = 1'b1;
        goto(14); a_w = 1'b1;
        goto(16); a_w = 1'b0;
        goto(18); a_w = 1'b1;
        goto(22);
        check("wrap_count", 32'(got_w.size()), 32'd2);
        if (got_w.size() == 2) begin
            check("wrap_rec0", 32'(got_w[0]), 32'({2'b01, 4'd14}));
            check("wrap_rec1", 32'(got_w[1]), 32'({2'b01, 4'd2}));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
